// File: rtl/run_sequencer_if.sv
// Memory-port and core start/done bundle between run_sequencer (master) and its
// memory/core (slave).
interface run_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) ();
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              dut_start;
  logic              dut_done;

  modport master (
    output mem_we, mem_addr, mem_wdata, dut_start,
    input  mem_rdata, dut_done
  );

  modport slave (
    input  mem_we, mem_addr, mem_wdata, dut_start,
    output mem_rdata, dut_done
  );
endinterface

// File: rtl/run_sequencer.sv
// Run controller: clears and preloads data memory, launches the core, waits for
// done under a watchdog, then reads back and checks result words.
module run_sequencer #(
  parameter  int unsigned ADDR_W     = 8,
  parameter  int unsigned DATA_W     = 8,
  parameter  int unsigned NUM_LOADS  = 4,
  parameter  int unsigned NUM_CHECKS = 4,
  parameter  int unsigned START_CYC  = 2,
  parameter  int unsigned TIMEOUT    = 4096,
  localparam int unsigned CNT_W      = $clog2(TIMEOUT + 1),
  localparam int unsigned FC_W       = $clog2(NUM_CHECKS + 1),
  localparam int unsigned FF_W       = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                         CLK,
  input  logic                         reset_n,
  input  logic                         go,
  input  logic [NUM_LOADS*ADDR_W-1:0]  load_addr,
  input  logic [NUM_LOADS*DATA_W-1:0]  load_data,
  input  logic [NUM_CHECKS*ADDR_W-1:0] chk_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0] chk_data,
  run_sequencer_if.master              bus,
  output logic                         busy,
  output logic                         finished,
  output logic                         pass,
  output logic                         timed_out,
  output logic [CNT_W-1:0]             cycle_count,
  output logic [FC_W-1:0]              fail_count,
  output logic [FF_W-1:0]              first_fail
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned M1      = (DEPTH > NUM_LOADS) ? DEPTH : NUM_LOADS;
  localparam int unsigned M2      = (M1 > START_CYC) ? M1 : START_CYC;
  localparam int unsigned IDX_MAX = (M2 > NUM_CHECKS + 1) ? M2 : NUM_CHECKS + 1;
  localparam int unsigned IDX_W   = $clog2(IDX_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_LAUNCH, S_RUN, S_CHECK, S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              start_q, start_d;
  logic              busy_d, finished_d, pass_d, to_d;
  logic [CNT_W-1:0]  cyc_d;
  logic [FC_W-1:0]   fc_d;
  logic [FF_W-1:0]   ff_d;
  int unsigned       nxt, prv;

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.dut_start = start_q;

  // Next state plus next registered outputs; every output is a flop fed from here.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = '0;
    cyc_d   = cycle_count;
    to_d    = timed_out;
    fc_d    = fail_count;
    ff_d    = first_fail;
    pass_d  = pass;
    nxt     = 32'(idx_q) + 32'd1;
    prv     = 32'(idx_q) - 32'd1;

    case (state_q)
      S_IDLE, S_FINISH: begin
        if (go) begin
          state_d = S_CLEAR;
          idx_d   = '0;
          we_d    = 1'b1;
          addr_d  = '0;
          cyc_d   = '0;
          to_d    = 1'b0;
          fc_d    = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
        end
      end
      S_CLEAR: begin
        we_d = 1'b1;
        if (idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = S_LOAD;
          idx_d   = '0;
          addr_d  = load_addr[0 +: ADDR_W];
          wdata_d = load_data[0 +: DATA_W];
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          addr_d = ADDR_W'(nxt);
        end
      end
      // Entries go out in index order, so a later duplicate address overwrites.
      S_LOAD: begin
        if (idx_q == IDX_W'(NUM_LOADS - 1)) begin
          state_d = S_LAUNCH;
          idx_d   = '0;
        end else begin
          we_d    = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
          addr_d  = load_addr[nxt*ADDR_W +: ADDR_W];
          wdata_d = load_data[nxt*DATA_W +: DATA_W];
        end
      end
      S_LAUNCH: begin
        if (idx_q == IDX_W'(START_CYC - 1)) begin
          state_d = S_RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_RUN: begin
        if (bus.dut_done) begin
          state_d = S_CHECK;
          idx_d   = '0;
          addr_d  = chk_addr[0 +: ADDR_W];
        end else begin
          cyc_d = cycle_count + CNT_W'(1);
          if (cycle_count == CNT_W'(TIMEOUT - 1)) begin
            to_d    = 1'b1;
            state_d = S_CHECK;
            idx_d   = '0;
            addr_d  = chk_addr[0 +: ADDR_W];
          end
        end
      end
      // Address for entry i goes out in cycle i; its read data is compared in cycle i+1.
      S_CHECK: begin
        if (idx_q != '0) begin
          if (bus.mem_rdata != chk_data[prv*DATA_W +: DATA_W]) begin
            if (fail_count == '0) ff_d = FF_W'(prv);
            fc_d = fail_count + FC_W'(1);
          end
        end
        if (idx_q == IDX_W'(NUM_CHECKS)) begin
          state_d = S_FINISH;
          pass_d  = (fc_d == '0) && !timed_out;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (nxt < NUM_CHECKS) addr_d = chk_addr[nxt*ADDR_W +: ADDR_W];
        end
      end
      default: state_d = S_IDLE;
    endcase

    start_d    = (state_d != S_RUN);
    busy_d     = (state_d != S_IDLE) && (state_d != S_FINISH);
    finished_d = (state_d == S_FINISH);
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      start_q     <= 1'b1;
      busy        <= 1'b0;
      finished    <= 1'b0;
      pass        <= 1'b0;
      timed_out   <= 1'b0;
      cycle_count <= '0;
      fail_count  <= '0;
      first_fail  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      start_q     <= start_d;
      busy        <= busy_d;
      finished    <= finished_d;
      pass        <= pass_d;
      timed_out   <= to_d;
      cycle_count <= cyc_d;
      fail_count  <= fc_d;
      first_fail  <= ff_d;
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: behavioural memory and core models plus a
// table-level reference model of the expected run outcome.
module tb_run_sequencer;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NL     = 4;
  localparam int unsigned NC     = 4;
  localparam int unsigned SC     = 2;
  localparam int unsigned TO     = 100;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned CNT_W  = $clog2(TO + 1);
  localparam int unsigned FC_W   = $clog2(NC + 1);
  localparam int unsigned FF_W   = $clog2(NC);

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                 reset_n, go;
  logic [NL*ADDR_W-1:0] load_addr;
  logic [NL*DATA_W-1:0] load_data;
  logic [NC*ADDR_W-1:0] chk_addr;
  logic [NC*DATA_W-1:0] chk_data;
  logic                 busy, finished, pass, timed_out;
  logic [CNT_W-1:0]     cycle_count;
  logic [FC_W-1:0]      fail_count;
  logic [FF_W-1:0]      first_fail;

  run_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  run_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_LOADS(NL), .NUM_CHECKS(NC),
    .START_CYC(SC), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .reset_n(reset_n), .go(go),
    .load_addr(load_addr), .load_data(load_data),
    .chk_addr(chk_addr), .chk_data(chk_data),
    .bus(bus),
    .busy(busy), .finished(finished), .pass(pass), .timed_out(timed_out),
    .cycle_count(cycle_count), .fail_count(fail_count), .first_fail(first_fail)
  );

  // Synchronous-read data memory; preset_req fills every word with preset_val.
  logic [7:0] mem [DEPTH];
  bit         preset_req = 1'b0;
  logic [7:0] preset_val = 8'hAA;
  int         we_cnt = 0;
  always @(posedge CLK) begin
    if (preset_req) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= preset_val;
    end else if (bus.mem_we === 1'b1) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_we === 1'b1) we_cnt <= we_cnt + 1;
  end

  // Core model: mode 0 raises done done_delay cycles after start falls,
  // mode 1 never raises it, mode 2 holds it high permanently.
  int core_cnt   = 0;
  int done_mode  = 0;
  int done_delay = 50;
  always @(posedge CLK) begin
    #1;
    if (bus.dut_start === 1'b0) core_cnt = core_cnt + 1;
    else core_cnt = 0;
    case (done_mode)
      0:       bus.dut_done = (bus.dut_start === 1'b0) && (core_cnt > done_delay);
      1:       bus.dut_done = 1'b0;
      default: bus.dut_done = 1'b1;
    endcase
  end

  logic [7:0] la [NL];
  logic [7:0] ld [NL];
  logic [7:0] ca [NC];
  logic [7:0] cd [NC];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [7:0] model_word(input logic [7:0] a);
    logic [7:0] v = 8'h00;
    for (int i = 0; i < NL; i++) if (la[i] == a) v = ld[i];
    return v;
  endfunction

  task automatic pack_tables();
    for (int i = 0; i < NL; i++) begin
      load_addr[i*ADDR_W +: ADDR_W] = la[i];
      load_data[i*DATA_W +: DATA_W] = ld[i];
    end
    for (int i = 0; i < NC; i++) begin
      chk_addr[i*ADDR_W +: ADDR_W] = ca[i];
      chk_data[i*DATA_W +: DATA_W] = cd[i];
    end
  endtask

  task automatic set_scenario2();
    la = '{8'd1, 8'd0, 8'd64, 8'd65};
    ld = '{8'h03, 8'h78, 8'h90, 8'h6D};
    ca = '{8'd64, 8'd65, 8'd1, 8'd0};
    cd = '{8'h90, 8'h6D, 8'h03, 8'h78};
    done_mode  = 0;
    done_delay = 50;
  endtask

  task automatic run_and_check(input string tag, input bit busy_go);
    int exp_cyc, exp_fc, exp_ff, edges, w, we0, bad;
    bit exp_to, exp_pass;
    pack_tables();
    preset_req = 1'b1;
    @(posedge CLK);
    #1 preset_req = 1'b0;

    exp_to  = (done_mode == 1) || (done_mode == 0 && done_delay >= int'(TO));
    exp_cyc = (done_mode == 2) ? 0 : (exp_to ? int'(TO) : done_delay);
    exp_fc  = 0;
    exp_ff  = 0;
    for (int i = 0; i < NC; i++) begin
      if (model_word(ca[i]) != cd[i]) begin
        if (exp_fc == 0) exp_ff = i;
        exp_fc++;
      end
    end
    exp_pass = (exp_fc == 0) && !exp_to;

    we0 = we_cnt;
    @(negedge CLK) go = 1'b1;
    @(posedge CLK);
    #1 go = 1'b0;
    edges = 0;
    while (bus.dut_start !== 1'b0 && edges < 2000) begin
      go = (busy_go && edges == 100);
      @(posedge CLK);
      #1 edges++;
    end
    go = 1'b0;

    // Edges from the one that samples go until start is observed low.
    n_vec++;
    if (edges != int'(DEPTH + NL + SC)) begin
      $display("FAIL %s launch_latency: got %0d edges, expected %0d", tag, edges, DEPTH + NL + SC);
      n_err++;
    end
    n_vec++;
    if (busy !== 1'b1) begin
      $display("FAIL %s busy_in_run: got %b expected 1", tag, busy);
      n_err++;
    end

    w = 0;
    while (finished !== 1'b1 && w < 1000) begin
      @(posedge CLK);
      #1 w++;
    end
    n_vec++;
    if (finished !== 1'b1) begin
      $display("FAIL %s finish_timeout: finished=%b after %0d cycles", tag, finished, w);
      n_err++;
    end
    n_vec++;
    if (pass !== exp_pass) begin
      $display("FAIL %s pass: got %b expected %b", tag, pass, exp_pass);
      n_err++;
    end
    n_vec++;
    if (timed_out !== exp_to) begin
      $display("FAIL %s timed_out: got %b expected %b", tag, timed_out, exp_to);
      n_err++;
    end
    n_vec++;
    if (cycle_count !== CNT_W'(exp_cyc)) begin
      $display("FAIL %s cycle_count: got %0d expected %0d", tag, cycle_count, exp_cyc);
      n_err++;
    end
    n_vec++;
    if (fail_count !== FC_W'(exp_fc)) begin
      $display("FAIL %s fail_count: got %0d expected %0d", tag, fail_count, exp_fc);
      n_err++;
    end
    n_vec++;
    if (first_fail !== FF_W'(exp_ff)) begin
      $display("FAIL %s first_fail: got %0d expected %0d", tag, first_fail, exp_ff);
      n_err++;
    end
    n_vec++;
    if (bus.dut_start !== 1'b1 || busy !== 1'b0 || bus.mem_we !== 1'b0) begin
      $display("FAIL %s finish_outputs: start=%b busy=%b we=%b expected 1 0 0",
               tag, bus.dut_start, busy, bus.mem_we);
      n_err++;
    end
    n_vec++;
    if (we_cnt - we0 != int'(DEPTH + NL)) begin
      $display("FAIL %s write_cycles: got %0d expected %0d", tag, we_cnt - we0, DEPTH + NL);
      n_err++;
    end
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== model_word(8'(a))) bad++;
    n_vec++;
    if (bad != 0) begin
      $display("FAIL %s mem_image: %0d words differ, expected 0", tag, bad);
      n_err++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    go      = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_vec++;
    if (busy !== 1'b0 || finished !== 1'b0 || pass !== 1'b0 || timed_out !== 1'b0) begin
      $display("FAIL reset status: busy=%b finished=%b pass=%b to=%b expected 0 0 0 0",
               busy, finished, pass, timed_out);
      n_err++;
    end
    n_vec++;
    if (bus.dut_start !== 1'b1 || bus.mem_we !== 1'b0) begin
      $display("FAIL reset core_mem: start=%b we=%b expected 1 0", bus.dut_start, bus.mem_we);
      n_err++;
    end
    n_vec++;
    if (cycle_count !== '0 || fail_count !== '0 || first_fail !== '0) begin
      $display("FAIL reset counters: cyc=%0d fc=%0d ff=%0d expected 0 0 0",
               cycle_count, fail_count, first_fail);
      n_err++;
    end
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    int w;
    set_scenario2();
    pack_tables();
    @(negedge CLK) go = 1'b1;
    @(posedge CLK);
    #1 go = 1'b0;
    w = 0;
    while (bus.dut_start !== 1'b0 && w < 2000) begin
      @(posedge CLK);
      #1 w++;
    end
    repeat (10) @(posedge CLK);
    @(negedge CLK) reset_n = 1'b0;
    @(posedge CLK);
    #1;
    n_vec++;
    if (busy !== 1'b0 || bus.dut_start !== 1'b1 || cycle_count !== '0 || finished !== 1'b0) begin
      $display("FAIL midrun_reset: busy=%b start=%b cyc=%0d finished=%b expected 0 1 0 0",
               busy, bus.dut_start, cycle_count, finished);
      n_err++;
    end
    reset_n = 1'b1;
    run_and_check("rerun_after_reset", 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NL; i++) begin
        la[i] = 8'($urandom_range(0, 15));
        ld[i] = 8'($urandom);
      end
      for (int i = 0; i < NC; i++) begin
        ca[i] = ($urandom_range(0, 1) == 1) ? la[$urandom_range(0, NL - 1)] : 8'($urandom);
        cd[i] = ($urandom_range(0, 3) != 0) ? model_word(ca[i]) : 8'($urandom);
      end
      done_mode  = ($urandom_range(0, 5) == 0) ? 2 : 0;
      done_delay = $urandom_range(0, 120);
      run_and_check($sformatf("random%0d", it), 1'(it % 2));
    end
  endtask

  initial begin
    load_addr = '0;
    load_data = '0;
    chk_addr  = '0;
    chk_data  = '0;
    test_reset();

    set_scenario2();
    run_and_check("pass_run", 1'b0);

    set_scenario2();
    cd[1] = 8'h6C;
    run_and_check("mismatch_run", 1'b0);

    set_scenario2();
    done_mode = 1;
    run_and_check("timeout_run", 1'b0);

    test_reset_mid_run();

    la = '{8'd5, 8'd7, 8'd9, 8'd5};
    ld = '{8'h11, 8'h33, 8'h44, 8'h22};
    ca = '{8'd5, 8'd7, 8'd9, 8'd6};
    cd = '{8'h22, 8'h33, 8'h44, 8'h00};
    done_mode = 2;
    run_and_check("dup_busy_go_instant_done", 1'b1);

    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
